// File: rtl/coherence_pkg.sv
// Shared MSI coherence types and the snoop action decode used by bus_snoop_controller.
package coherence_pkg;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_M = 2'b01,
        MSI_S = 2'b10
    } msi_state_e;

    typedef enum logic [1:0] {
        MSG_INVALIDATE = 2'b00,
        MSG_WRITE_MISS = 2'b01,
        MSG_READ_MISS  = 2'b10
    } bus_msg_e;

    typedef enum logic [1:0] {
        SNP_IDLE,
        SNP_WB,
        SNP_UPD
    } snoop_state_e;

    typedef struct packed {
        logic       flush;
        logic       wr_en;
        msi_state_e wr_val;
        logic       err;
    } snoop_action_t;

    // A tag miss behaves exactly like a hit on an Invalid line.
    function automatic snoop_action_t decode_action(input logic own, input logic hit,
                                                    input logic [1:0] line, input logic [1:0] msg);
        snoop_action_t act;
        logic [1:0]    cur;
        act = '{flush: 1'b0, wr_en: 1'b0, wr_val: MSI_I, err: 1'b0};
        cur = hit ? line : MSI_I;
        if (msg == 2'b11) begin
            act.err = 1'b1;
        end else if (!own) begin
            case (cur)
                MSI_S: if (msg != MSG_READ_MISS) act.wr_en = 1'b1;
                MSI_M: begin
                    if (msg == MSG_INVALIDATE) begin
                        act.err = 1'b1;
                    end else begin
                        act.flush  = 1'b1;
                        act.wr_en  = 1'b1;
                        act.wr_val = (msg == MSG_READ_MISS) ? MSI_S : MSI_I;
                    end
                end
                default: ;
            endcase
        end
        return act;
    endfunction

endpackage

// File: rtl/snoop_wb_sequencer.sv
// Writeback beat sequencer: walks one cache block over a valid/ready port after a start pulse.
module snoop_wb_sequencer #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic                           wb_ready,
    output logic                           wb_valid,
    output logic [ADDR_W-1:0]              wb_addr,
    output logic                           wb_last,
    output logic [$clog2(BLOCK_WORDS)-1:0] wb_rd_idx,
    output logic                           abort_mem,
    output logic                           done
);

    localparam int unsigned IDX_W  = $clog2(BLOCK_WORDS);
    localparam int unsigned STRIDE = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS * STRIDE);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    logic             busy_q, busy_d;
    logic             first_q, first_d;
    logic [IDX_W-1:0] beat_q, beat_d;

    assign wb_valid  = busy_q;
    assign wb_rd_idx = beat_q;
    assign abort_mem = first_q;
    assign wb_last   = busy_q && (beat_q == IDX_W'(BLOCK_WORDS - 1));
    assign wb_addr   = busy_q ? (base_addr & ~OFF_MASK) + ADDR_W'(beat_q) * ADDR_W'(STRIDE) : '0;

    always_comb begin
        busy_d  = busy_q;
        first_d = 1'b0;
        beat_d  = beat_q;
        done    = 1'b0;
        if (start) begin
            busy_d  = 1'b1;
            first_d = 1'b1;
            beat_d  = '0;
        end else if (busy_q && wb_ready) begin
            // Power-of-two block: the increment after the last beat wraps to 0.
            beat_d = beat_q + IDX_W'(1);
            if (wb_last) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            first_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            first_q <= first_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/bus_snoop_controller.sv
// MSI snoop-side responder: decodes bus messages, flushes Modified lines, updates line state.
// Optional statistics counters are enabled by defining SNOOP_STATS_EN.
module bus_snoop_controller
    import coherence_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned CORE_ID     = 0,
    parameter int unsigned CORE_ID_W   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           snoop_valid,
    output logic                           snoop_ready,
    input  logic [1:0]                     snoop_msg,
    input  logic [ADDR_W-1:0]              snoop_addr,
    input  logic [CORE_ID_W-1:0]           snoop_src,
    input  logic                           lookup_hit,
    input  logic [1:0]                     line_state,
    output logic                           state_wr_en,
    output logic [1:0]                     state_wr_val,
    output logic                           wb_valid,
    input  logic                           wb_ready,
    output logic [ADDR_W-1:0]              wb_addr,
    output logic                           wb_last,
    output logic [$clog2(BLOCK_WORDS)-1:0] wb_rd_idx,
    input  logic [DATA_W-1:0]              wb_rd_data,
    output logic [DATA_W-1:0]              wb_data,
    output logic                           abort_mem,
    output logic                           snoop_done,
    output logic                           err
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]                    stat_flush_cnt,
    output logic [15:0]                    stat_inval_cnt
`endif
);

    snoop_state_e      state_q, state_d;
    logic              ready_q, ready_d;
    snoop_action_t     action_q, action_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    snoop_action_t     live_action;
    logic              wb_start;
    logic              wb_done;

    assign live_action = decode_action(snoop_src == CORE_ID_W'(CORE_ID), lookup_hit, line_state, snoop_msg);
    assign snoop_ready = ready_q;
    assign wb_data     = wb_rd_data;

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        action_d     = action_q;
        addr_d       = addr_q;
        wb_start     = 1'b0;
        state_wr_en  = 1'b0;
        state_wr_val = MSI_I;
        snoop_done   = 1'b0;
        err          = 1'b0;
        case (state_q)
            SNP_IDLE: begin
                ready_d = 1'b1;
                if (snoop_valid && ready_q) begin
                    action_d = live_action;
                    addr_d   = snoop_addr;
                    ready_d  = 1'b0;
                    wb_start = live_action.flush;
                    state_d  = live_action.flush ? SNP_WB : SNP_UPD;
                end
            end
            SNP_WB: begin
                if (wb_done || !action_q.flush) state_d = SNP_UPD;
            end
            SNP_UPD: begin
                state_wr_en  = action_q.wr_en;
                state_wr_val = action_q.wr_val;
                err          = action_q.err;
                snoop_done   = 1'b1;
                ready_d      = 1'b1;
                state_d      = SNP_IDLE;
            end
            default: state_d = SNP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SNP_IDLE;
            ready_q  <= 1'b0;
            action_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            action_q <= action_d;
            addr_q   <= addr_d;
        end
    end

    snoop_wb_sequencer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_wb_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (wb_start),
        .base_addr (addr_q),
        .wb_ready  (wb_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_last   (wb_last),
        .wb_rd_idx (wb_rd_idx),
        .abort_mem (abort_mem),
        .done      (wb_done)
    );

`ifdef SNOOP_STATS_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] inval_cnt_q, inval_cnt_d;

    // Every non-flush state write is an S->I invalidation.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        inval_cnt_d = inval_cnt_q;
        if (state_q == SNP_UPD) begin
            if (action_q.flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 16'd1;
            if (action_q.wr_en && !action_q.flush && inval_cnt_q != '1) inval_cnt_d = inval_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            inval_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            inval_cnt_q <= inval_cnt_d;
        end
    end

    assign stat_flush_cnt = flush_cnt_q;
    assign stat_inval_cnt = inval_cnt_q;
`endif

endmodule

// File: tb/tb_bus_snoop_controller.sv
// Self-checking bench for bus_snoop_controller: directed vector table, random transactions, reset corners.
module tb_bus_snoop_controller;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BW     = 4;
    localparam int unsigned CID    = 0;
    localparam int unsigned CIDW   = 2;

    logic        clk, rst_n;
    logic        snoop_valid, snoop_ready;
    logic [1:0]  snoop_msg;
    logic [31:0] snoop_addr;
    logic [1:0]  snoop_src;
    logic        lookup_hit;
    logic [1:0]  line_state;
    logic        state_wr_en;
    logic [1:0]  state_wr_val;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_addr;
    logic        wb_last;
    logic [1:0]  wb_rd_idx;
    logic [31:0] wb_rd_data, wb_data;
    logic        abort_mem, snoop_done, err;
`ifdef SNOOP_STATS_EN
    logic [15:0] stat_flush_cnt, stat_inval_cnt;
`endif

    logic [31:0] mem [4];
    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       flush;
        logic       wr;
        logic [1:0] val;
        logic       err;
    } act_t;

    typedef struct {
        logic [1:0]  msg;
        logic [31:0] addr;
        logic [1:0]  src;
        logic        hit;
        logic [1:0]  line;
        act_t        exp;
        int          mode;
        int          stall;
    } vec_t;

    vec_t vecs [11];

    bus_snoop_controller #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BLOCK_WORDS (BW),
        .CORE_ID     (CID),
        .CORE_ID_W   (CIDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snoop_valid  (snoop_valid),
        .snoop_ready  (snoop_ready),
        .snoop_msg    (snoop_msg),
        .snoop_addr   (snoop_addr),
        .snoop_src    (snoop_src),
        .lookup_hit   (lookup_hit),
        .line_state   (line_state),
        .state_wr_en  (state_wr_en),
        .state_wr_val (state_wr_val),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_last      (wb_last),
        .wb_rd_idx    (wb_rd_idx),
        .wb_rd_data   (wb_rd_data),
        .wb_data      (wb_data),
        .abort_mem    (abort_mem),
        .snoop_done   (snoop_done),
        .err          (err)
`ifdef SNOOP_STATS_EN
        ,
        .stat_flush_cnt (stat_flush_cnt),
        .stat_inval_cnt (stat_inval_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb wb_rd_data = mem[wb_rd_idx];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the MSI snoop response table, miss treated as Invalid.
    function automatic act_t model(input logic [1:0] msg, input logic [1:0] src,
                                   input logic hit, input logic [1:0] line);
        act_t       a;
        logic [1:0] eff;
        a   = '0;
        eff = hit ? line : 2'b00;
        if (msg == 2'b11) a.err = 1'b1;
        else if (src == CIDW'(CID)) a = '0;
        else if (eff == 2'b01 && msg == 2'b00) a.err = 1'b1;
        else if (eff == 2'b01) begin
            a.flush = 1'b1;
            a.wr    = 1'b1;
            a.val   = (msg == 2'b10) ? 2'b10 : 2'b00;
        end else if (eff == 2'b10 && msg != 2'b10) begin
            a.wr  = 1'b1;
            a.val = 2'b00;
        end
        return a;
    endfunction

    task automatic run_snoop(input string tag, input logic [1:0] msg, input logic [31:0] addr,
                             input logic [1:0] src, input logic hit, input logic [1:0] line,
                             input act_t exp, input int mode, input int stall);
        int          cyc, beats, aborts, dones, spurious;
        logic        prev_stall;
        logic [31:0] prev_addr, prev_data, base;
        cyc = 0;
        while (!snoop_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk({tag, "_ready"}, snoop_ready, 1);
        for (int k = 0; k < 4; k++) mem[k] = $urandom;
        snoop_valid = 1'b1;
        snoop_msg   = msg;
        snoop_addr  = addr;
        snoop_src   = src;
        lookup_hit  = hit;
        line_state  = line;
        tick();
        snoop_valid = 1'b0;
        lookup_hit  = 1'($urandom);
        line_state  = 2'($urandom);
        snoop_msg   = 2'($urandom);
        base        = addr & ~32'hF;
        beats = 0; aborts = 0; dones = 0; spurious = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        cyc = 1;
        while (dones == 0 && cyc < 200) begin
            if (abort_mem) begin
                aborts++;
                chk({tag, "_abort_cycle"}, cyc, 1);
            end
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, wb_valid, 1);
                chk({tag, "_stall_addr"}, wb_addr, prev_addr);
                chk({tag, "_stall_data"}, wb_data, prev_data);
            end
            if (snoop_done) begin
                dones++;
                chk({tag, "_wr_en"}, state_wr_en, exp.wr);
                if (exp.wr) chk({tag, "_wr_val"}, state_wr_val, exp.val);
                chk({tag, "_err"}, err, exp.err);
                chk({tag, "_done_wbv"}, wb_valid, 0);
                if (!exp.flush) chk({tag, "_latency"}, cyc, 1);
            end else if (state_wr_en || err) begin
                spurious++;
            end
            case (mode)
                1:       wb_ready = (cyc % 2 == 1);
                2:       wb_ready = (cyc > stall);
                default: wb_ready = 1'($urandom);
            endcase
            if (wb_valid) begin
                if (wb_ready) begin
                    if (beats < 4) begin
                        chk({tag, "_beat_addr"}, wb_addr, base + 32'(beats * 4));
                        chk({tag, "_beat_data"}, wb_data, mem[beats]);
                        chk({tag, "_beat_last"}, wb_last, beats == 3);
                    end
                    beats++;
                end
                prev_stall = !wb_ready;
                prev_addr  = wb_addr;
                prev_data  = wb_data;
            end else begin
                prev_stall = 1'b0;
            end
            tick();
            cyc++;
        end
        wb_ready = 1'b0;
        chk({tag, "_done_seen"}, dones, 1);
        chk({tag, "_beats"}, beats, exp.flush ? 4 : 0);
        chk({tag, "_aborts"}, aborts, exp.flush ? 1 : 0);
        chk({tag, "_spurious"}, spurious, 0);
        chk({tag, "_ready_after"}, snoop_ready, 1);
        chk({tag, "_done_once"}, snoop_done, 0);
    endtask

    initial begin
        int n;
        act_t e;
        logic [1:0]  r_msg, r_src, r_line;
        logic        r_hit;

        //         msg    addr          src   hit   line    {flush,wr,val,err}      mode stall
        vecs[0]  = '{2'b00, 32'h0000_2000, 2'd1, 1'b1, 2'b10, '{1'b0,1'b1,2'b00,1'b0}, 0, 0};
        vecs[1]  = '{2'b10, 32'h0000_1004, 2'd1, 1'b1, 2'b01, '{1'b1,1'b1,2'b10,1'b0}, 1, 0};
        vecs[2]  = '{2'b01, 32'h0000_3008, 2'd2, 1'b1, 2'b01, '{1'b1,1'b1,2'b00,1'b0}, 2, 5};
        vecs[3]  = '{2'b10, 32'h0000_4000, 2'd0, 1'b1, 2'b01, '{1'b0,1'b0,2'b00,1'b0}, 0, 0};
        vecs[4]  = '{2'b00, 32'h0000_5000, 2'd1, 1'b1, 2'b01, '{1'b0,1'b0,2'b00,1'b1}, 0, 0};
        vecs[5]  = '{2'b11, 32'h0000_6000, 2'd1, 1'b1, 2'b10, '{1'b0,1'b0,2'b00,1'b1}, 0, 0};
        vecs[6]  = '{2'b10, 32'h0000_7000, 2'd3, 1'b1, 2'b10, '{1'b0,1'b0,2'b00,1'b0}, 0, 0};
        vecs[7]  = '{2'b01, 32'h0000_8000, 2'd1, 1'b0, 2'b01, '{1'b0,1'b0,2'b00,1'b0}, 0, 0};
        vecs[8]  = '{2'b01, 32'h0000_9000, 2'd1, 1'b1, 2'b00, '{1'b0,1'b0,2'b00,1'b0}, 0, 0};
        vecs[9]  = '{2'b01, 32'h0000_A000, 2'd2, 1'b1, 2'b10, '{1'b0,1'b1,2'b00,1'b0}, 0, 0};
        vecs[10] = '{2'b01, 32'hFFFF_FFFC, 2'd3, 1'b1, 2'b01, '{1'b1,1'b1,2'b00,1'b0}, 0, 0};

        rst_n = 1'b0; snoop_valid = 1'b0; snoop_msg = '0; snoop_addr = '0; snoop_src = '0;
        lookup_hit = 1'b0; line_state = '0; wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) mem[k] = '0;

        tick();
        tick();
        chk("rst_ready", snoop_ready, 0);
        chk("rst_outputs", {state_wr_en, state_wr_val, wb_valid, wb_last, abort_mem, snoop_done, err}, '0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_rd_idx", wb_rd_idx, 0);
        rst_n = 1'b1;
        chk("rst_release_ready_low", snoop_ready, 0);
        tick();
        chk("rst_release_ready", snoop_ready, 1);

        for (int i = 0; i < 11; i++)
            run_snoop($sformatf("vec%0d", i), vecs[i].msg, vecs[i].addr, vecs[i].src, vecs[i].hit,
                      vecs[i].line, vecs[i].exp, vecs[i].mode, vecs[i].stall);

        for (int i = 0; i < 60; i++) begin
            r_msg  = 2'($urandom_range(0, 3));
            r_src  = 2'($urandom_range(0, 3));
            r_hit  = 1'($urandom_range(0, 1));
            r_line = 2'($urandom_range(0, 2));
            e      = model(r_msg, r_src, r_hit, r_line);
            run_snoop($sformatf("rnd%0d", i), r_msg, $urandom, r_src, r_hit, r_line, e, 0, 0);
        end

        // Reset asserted while the third beat of a flush is pending.
        for (int k = 0; k < 4; k++) mem[k] = $urandom;
        chk("midrst_ready", snoop_ready, 1);
        snoop_valid = 1'b1; snoop_msg = 2'b10; snoop_addr = 32'h0000_C000;
        snoop_src = 2'd1; lookup_hit = 1'b1; line_state = 2'b01;
        tick();
        snoop_valid = 1'b0;
        wb_ready = 1'b1;
        n = 0;
        while (wb_rd_idx != 2'd2 && n < 20) begin
            tick();
            n++;
        end
        chk("midrst_reach_beat2", {wb_valid, wb_rd_idx}, {1'b1, 2'd2});
        wb_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_no_update", {state_wr_en, snoop_done, abort_mem, err}, '0);
        chk("midrst_ready_low", snoop_ready, 0);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (state_wr_en || snoop_done || wb_valid) n++;
        end
        chk("midrst_quiet_after", n, 0);
        chk("midrst_ready_after", snoop_ready, 1);

        run_snoop("post_rst", 2'b00, 32'h0000_D000, 2'd1, 1'b1, 2'b10, '{1'b0,1'b1,2'b00,1'b0}, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
